iter_mult_unit: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier; the execution-side responder for instructions the control unit decodes with ALUOp = MULT (2'b11).
- Sits beside the ALU in EX. Accepts operands via valid/ready, returns the low DATA_W bits of the product via valid/ready.
- Drives `busy` so hazard logic can stall upstream stages. Supports a synchronous `flush` for squashed instructions.

---
 rtl/iter_mult_unit_pkg.sv | 21 ++
 rtl/iter_mult_unit_step.sv | 31 +++
 rtl/iter_mult_unit.sv | 117 +++++++++++
 tb/tb_iter_mult_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_mult_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : mult_pkg                                                   |
// | Description : Shared types and constants for the iterative multiplier.   |
// |               State encoding, the control-unit ALUOp value that selects  |
// |               the multiplier, and the default operand width.             |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
package mult_pkg;

   localparam int         DEFAULT_DATA_W = 64;
   localparam logic [1:0] MULT_OPCODE    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/iter_mult_unit_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : mult_step                                                  |
// | Description : One radix-2 shift-add iteration, purely combinational.     |
// |               Adds the multiplicand into the accumulator when the        |
// |               multiplier LSB is set, then shifts multiplicand left and   |
// |               multiplier right (logical). Sums wrap modulo 2^DATA_W.     |
// | Ports       : i_acc/i_mcand/i_mplier - current iteration state           |
// |               o_acc/o_mcand/o_mplier - next iteration state              |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module mult_step
   import mult_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0] i_acc,
   input  logic [DATA_W-1:0] i_mcand,
   input  logic [DATA_W-1:0] i_mplier,
   output logic [DATA_W-1:0] o_acc,
   output logic [DATA_W-1:0] o_mcand,
   output logic [DATA_W-1:0] o_mplier
);

   // Truncation to DATA_W is the intended wrap-around behaviour.
   assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
   assign o_mcand  = i_mcand << 1;
   assign o_mplier = i_mplier >> 1;

endmodule
`default_nettype wire

// File: rtl/iter_mult_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : iter_mult_unit                                             |
// | Description : Multi-cycle radix-2 shift-add multiplier for the EX stage. |
// |               Returns the low DATA_W bits of op_a*op_b. One iteration    |
// |               per cycle; DATA_W cycles from acceptance to result_valid.  |
// | Option      : ITER_MULT_EARLY_TERM_EN - finish as soon as the remaining  |
// |               multiplier is zero (latency max(1, msb(op_b)+1)).          |
// | Ports       : clk, arst_n        - clock, async active-low reset         |
// |               start_valid/ready  - operand handshake (op_a, op_b)        |
// |               result_valid/ready - product handshake (result)            |
// |               flush              - synchronous abort, highest priority   |
// |               busy               - high in BUSY or DONE (hazard stall)   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module iter_mult_unit
   import mult_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic              flush,
   output logic              busy,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [DATA_W-1:0] result
);

   localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_W - 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_acc;
   logic [DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [CNT_W-1:0]  r_cnt;

   logic [DATA_W-1:0] w_acc_nxt;
   logic [DATA_W-1:0] w_mcand_nxt;
   logic [DATA_W-1:0] w_mplier_nxt;
   logic              w_finish;

   mult_step #(
      .DATA_W (DATA_W)
   ) u_step (
      .i_acc    (r_acc),
      .i_mcand  (r_mcand),
      .i_mplier (r_mplier),
      .o_acc    (w_acc_nxt),
      .o_mcand  (w_mcand_nxt),
      .o_mplier (w_mplier_nxt)
   );

`ifdef ITER_MULT_EARLY_TERM_EN
   // Once the remaining multiplier is zero no further adds can happen.
   assign w_finish = (r_cnt == c_LAST_CNT) || (w_mplier_nxt == '0);
`else
   assign w_finish = (r_cnt == c_LAST_CNT);
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         // Squashed instruction: drop everything, including a coincident start.
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start_valid) begin
                  r_mcand  <= op_a;
                  r_mplier <= op_b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= w_mcand_nxt;
               r_mplier <= w_mplier_nxt;
               r_cnt    <= r_cnt + 1'b1;
               if (w_finish) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs depend only on registered state, never on inputs.
   assign start_ready  = (r_state == ST_IDLE);
   assign busy         = (r_state != ST_IDLE);
   assign result_valid = (r_state == ST_DONE);
   assign result       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_iter_mult_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : tb_iter_mult_unit                                          |
// | Description : Self-checking bench for iter_mult_unit. A driver issues    |
// |               operations and queues expected product and latency; a     |
// |               monitor compares whenever the DUT presents a result.      |
// |               Honours ITER_MULT_EARLY_TERM_EN for the latency model.    |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module tb_iter_mult_unit;

   localparam int DW = 64;

   logic          clk;
   logic          arst_n;
   logic          start_valid;
   logic          start_ready;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          flush;
   logic          busy;
   logic          result_valid;
   logic          result_ready;
   logic [DW-1:0] result;

   iter_mult_unit #(.DATA_W(DW)) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] res;
      int            lat;
   } exp_t;

   exp_t          sb[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   logic          prev_valid = 1'b0;
   logic [DW-1:0] prev_result = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference model: plain arithmetic, wrapped to DW bits.
   function automatic logic [DW-1:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] full;
      full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      return full[DW-1:0];
   endfunction

   function automatic int ref_lat(input logic [DW-1:0] b);
`ifdef ITER_MULT_EARLY_TERM_EN
      int l;
      l = 1;
      for (int i = 0; i < DW; i++) if (b[i]) l = i + 1;
      return l;
`else
      return DW;
`endif
   endfunction

   // Monitor: samples 1 time unit after the falling edge.
   always @(negedge clk) begin
      #1;
      if (!arst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (result_valid && !prev_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got result_valid=1 expected 0 (result 0x%0h)", result);
            end else begin
               chk("latency", DW'(cyc - acc_cyc), DW'(sb[0].lat));
            end
         end
         if (result_valid && prev_valid) chk("hold_stable", result, prev_result);
         if (result_valid && result_ready && sb.size() > 0) begin
            chk("result", result, sb[0].res);
            void'(sb.pop_front());
         end
         prev_valid  = result_valid;
         prev_result = result;
      end
   end

   task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
      @(negedge clk);
      chk("start_ready_idle", DW'(start_ready), DW'(1));
      start_valid = 1'b1;
      op_a = a;
      op_b = b;
      @(negedge clk);
      acc_cyc = cyc;
      sb.push_back('{res: ref_prod(a, b), lat: ref_lat(b)});
      start_valid = 1'b0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!result_valid && n < 200) begin
         chk("start_ready_busy", DW'(start_ready), DW'(0));
         @(negedge clk);
         n++;
      end
      if (!result_valid) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got result_valid=0 expected 1 within 200 cycles");
      end
   endtask

   // Full operation with 'hold' cycles of back-pressure; during the hold a
   // competing start is offered and must be refused.
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
      issue(a, b);
      wait_valid();
      result_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         start_valid = 1'b1;
         op_a = {$urandom, $urandom};
         op_b = {$urandom, $urandom};
         @(negedge clk);
         chk("valid_held", DW'(result_valid), DW'(1));
         chk("no_start_in_done", DW'(start_ready), DW'(0));
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("idle_after_hs", DW'(start_ready), DW'(1));
      chk("busy_after_hs", DW'(busy), DW'(0));
   endtask

   initial begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      arst_n       = 1'b0;
      start_valid  = 1'b0;
      op_a         = '0;
      op_b         = '0;
      flush        = 1'b0;
      result_ready = 1'b0;
      repeat (3) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      chk("rst_start_ready", DW'(start_ready), DW'(1));
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_valid", DW'(result_valid), DW'(0));
      chk("rst_result", result, '0);

      // Directed products and wrap cases.
      run_op(64'd3, 64'd5, 0);
      run_op('1, '1, 0);
      run_op(64'h8000_0000_0000_0000, 64'd2, 0);
      run_op(64'h1234_5678_9abc_def0, 64'd5, 10);
      run_op(64'h1234_5678_9abc_def0, 64'd0, 1);

      // Flush mid-BUSY, then a normal 7x6.
      issue(64'd11, 64'd13);
      void'(sb.pop_front());
      repeat (19) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", DW'(start_ready), DW'(1));
      chk("flush_busy", DW'(busy), DW'(0));
      chk("flush_result", result, '0);
      repeat (80) @(negedge clk);
      chk("flush_no_valid", DW'(result_valid), DW'(0));
      run_op(64'd7, 64'd6, 0);

      // Flush coincident with start in IDLE: start refused.
      @(negedge clk);
      start_valid = 1'b1;
      flush = 1'b1;
      op_a = 64'd9;
      op_b = 64'd9;
      @(negedge clk);
      start_valid = 1'b0;
      flush = 1'b0;
      chk("flush_start_refused", DW'(busy), DW'(0));

      // Asynchronous reset mid-BUSY.
      issue(64'hdead_beef, 64'hffff_ffff_ffff_fff1);
      repeat (10) @(negedge clk);
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_busy", DW'(busy), DW'(0));
      chk("arst_start_ready", DW'(start_ready), DW'(1));
      chk("arst_valid", DW'(result_valid), DW'(0));
      chk("arst_result", result, '0);
      sb.delete();
      @(negedge clk);
      arst_n = 1'b1;
      run_op(64'd100, 64'd200, 0);

      // Randomized operands, mixing narrow multipliers for variable latency.
      for (int k = 0; k < 20; k++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = 64'($urandom_range(0, 15));
            1:       b = 64'($urandom);
            2:       b = '1;
            default: b = {$urandom, $urandom};
         endcase
         run_op(a, b, int'($urandom_range(0, 3)));
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", DW'(sb.size()), DW'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
